// File: rtl/matcher_pkg.sv
// Shared types and default widths for the matcher result collector.
package matcher_pkg;

    localparam int DEFAULT_DATA_WIDTH = 64;
    localparam int DEFAULT_BEAT_WIDTH = 32;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    typedef struct packed {
        logic [DEFAULT_BEAT_WIDTH-1:0] beat;
        logic [DEFAULT_DATA_WIDTH-1:0] data;
    } entry_t;

endpackage

// File: rtl/matcher_result_fifo.sv
// First-word-fall-through FIFO for tagged match results.
module matcher_result_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 16
) (
    input  logic                       fclk,
    input  logic                       areset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    // Full/empty come from registered occupancy, so a same-cycle pop never frees a slot for a push.
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge fclk) begin
        if (!areset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge fclk) begin
        if (wr_en) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/matcher_result_collector.sv
// Captures matcher results with a beat tag, acknowledges the matcher, buffers and drains them,
// and keeps saturating match / no-match statistics.
module matcher_result_collector
    import matcher_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BEAT_WIDTH = DEFAULT_BEAT_WIDTH,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  fclk,
    input  logic                  areset_n,
    input  logic                  data_valid,
    input  logic                  result_valid,
    input  logic                  result_match,
    input  logic [DATA_WIDTH-1:0] result_data,
    output logic                  result_reset,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [BEAT_WIDTH-1:0] m_beat,
    output logic [CNT_WIDTH-1:0]  match_count,
    output logic [CNT_WIDTH-1:0]  done_count,
    input  logic                  clear
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t                           state;
    state_t                           state_nxt;
    logic [BEAT_WIDTH-1:0]            beat_cnt;
    logic                             fifo_full;
    logic                             fifo_empty;
    logic [CW-1:0]                    fifo_count;
    logic [BEAT_WIDTH+DATA_WIDTH-1:0] fifo_rdata;
    logic                             capture;
    logic                             no_match;
    logic                             pop;

    // A match seen during ACK is the one just captured, so only IDLE may capture.
    assign capture  = (state == IDLE) && result_valid && result_match && !fifo_full;
    assign no_match = result_valid && !result_match;
    assign m_valid  = (fifo_count != '0);
    assign pop      = m_ready && !fifo_empty;
    assign {m_beat, m_data} = fifo_rdata;

    always_ff @(posedge fclk) begin
        if (!areset_n) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (capture) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        result_reset = (state == ACK);
    end

    always_ff @(posedge fclk) begin
        if (!areset_n)       beat_cnt <= '0;
        else if (data_valid) beat_cnt <= beat_cnt + BEAT_WIDTH'(1);
    end

    // Statistics saturate; clear dominates a coincident event.
    always_ff @(posedge fclk) begin
        if (!areset_n || clear) begin
            match_count <= '0;
            done_count  <= '0;
        end else begin
            if (capture && (match_count != '1)) match_count <= match_count + CNT_WIDTH'(1);
            if (no_match && (done_count != '1)) done_count  <= done_count + CNT_WIDTH'(1);
        end
    end

    matcher_result_fifo #(
        .WIDTH (BEAT_WIDTH + DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .fclk     (fclk),
        .areset_n (areset_n),
        .push     (capture),
        .wdata    ({beat_cnt, result_data}),
        .pop      (pop),
        .rdata    (fifo_rdata),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_matcher_result_collector.sv
// Randomized self-checking bench for matcher_result_collector against a queue-based reference model.
module tb_matcher_result_collector;

    localparam int DW    = 64;
    localparam int BW    = 32;
    localparam int DEPTH = 16;
    localparam int CW    = 5;
    localparam int CMAX  = (1 << CW) - 1;

    logic          fclk = 1'b0;
    logic          areset_n;
    logic          data_valid;
    logic          result_valid;
    logic          result_match;
    logic [DW-1:0] result_data;
    logic          result_reset;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [BW-1:0] m_beat;
    logic [CW-1:0] match_count;
    logic [CW-1:0] done_count;
    logic          clear;

    typedef struct {
        logic [BW-1:0] beat;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          q[$];
    logic [BW-1:0] mdl_beat;
    int            mdl_match;
    int            mdl_done;
    bit            mdl_ack;
    int            errors = 0;
    int            checks = 0;

    matcher_result_collector #(
        .DATA_WIDTH (DW),
        .BEAT_WIDTH (BW),
        .FIFO_DEPTH (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .fclk         (fclk),
        .areset_n     (areset_n),
        .data_valid   (data_valid),
        .result_valid (result_valid),
        .result_match (result_match),
        .result_data  (result_data),
        .result_reset (result_reset),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_beat       (m_beat),
        .match_count  (match_count),
        .done_count   (done_count),
        .clear        (clear)
    );

    always #5 fclk = ~fclk;

    // Advance one clock; the model sees the same inputs the DUT sees at the edge.
    task automatic tick();
        bit full, popd, cap;
        @(posedge fclk);
        if (!areset_n) begin
            q.delete();
            mdl_ack = 0; mdl_beat = '0; mdl_match = 0; mdl_done = 0;
        end else begin
            full = (q.size() == DEPTH);
            popd = (q.size() != 0) && m_ready;
            cap  = !mdl_ack && result_valid && result_match && !full;
            if (popd) void'(q.pop_front());
            if (cap) q.push_back('{beat: mdl_beat, data: result_data});
            if (clear) begin
                mdl_match = 0; mdl_done = 0;
            end else begin
                if (cap && mdl_match < CMAX) mdl_match++;
                if (result_valid && !result_match && mdl_done < CMAX) mdl_done++;
            end
            mdl_ack = cap;
            if (data_valid) mdl_beat = mdl_beat + 1;
        end
        @(negedge fclk);
    endtask

    // Behave like the matcher: hold a match until released, keep it through the ACK edge, then drop.
    task automatic present(input logic [DW-1:0] d, input bit rand_dv, input int budget,
                           output bit released, output int lat);
        released = 0; lat = 0;
        result_valid = 1; result_match = 1; result_data = d;
        for (int i = 0; i < budget && !released; i++) begin
            data_valid = rand_dv ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            lat++;
            if (result_reset === 1'b1) released = 1;
        end
        if (released) tick();
        result_valid = 0; result_match = 0; data_valid = 0;
    endtask

    task automatic test_reset();
        areset_n = 0; data_valid = 1; result_valid = 1; result_match = 1; m_ready = 0; clear = 0;
        result_data = 64'h1234;
        tick(); tick();
        data_valid = 0; result_valid = 0; result_match = 0;
        checks++;
        if ({result_reset, m_valid, m_data, m_beat, match_count, done_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rr=%0b mv=%0b md=%h mb=%0d mc=%0d dc=%0d want all zero",
                     result_reset, m_valid, m_data, m_beat, match_count, done_count);
        end
        areset_n = 1;
        tick();
        checks++;
        if (result_reset !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got rr=%0b mv=%0b want 0 0", result_reset, m_valid);
        end
    endtask

    task automatic test_single_match();
        bit rel; int lat;
        data_valid = 1; tick(); tick(); tick(); data_valid = 0;
        present(64'hDEADBEEF, 0, 8, rel, lat);
        checks++;
        if (!rel || lat != 1) begin
            errors++;
            $display("FAIL single_release: got released=%0b latency=%0d want 1 1", rel, lat);
        end
        checks++;
        if (result_reset !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse_width: got rr=%0b after ACK want 0", result_reset);
        end
        checks++;
        if (m_valid !== 1'b1 || m_data !== 64'hDEADBEEF || m_beat !== 32'd3 || match_count !== 5'd1) begin
            errors++;
            $display("FAIL single_entry: got mv=%0b md=%h mb=%0d mc=%0d want 1 deadbeef 3 1",
                     m_valid, m_data, m_beat, match_count);
        end
        m_ready = 1; tick(); m_ready = 0;
        checks++;
        if (m_valid !== 1'b0 || q.size() != 0) begin
            errors++;
            $display("FAIL single_drain: got mv=%0b want 0", m_valid);
        end
    endtask

    task automatic test_no_match();
        result_valid = 1; result_match = 0; tick();
        result_valid = 0;
        checks++;
        if (done_count !== 5'd1 || result_reset !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_match: got dc=%0d rr=%0b mv=%0b want 1 0 0", done_count, result_reset, m_valid);
        end
        tick();
        checks++;
        if (result_reset !== 1'b0 || match_count !== 5'd1) begin
            errors++;
            $display("FAIL no_match_quiet: got rr=%0b mc=%0d want 0 1", result_reset, match_count);
        end
    endtask

    task automatic test_backpressure();
        bit rel; int lat; int bad = 0;
        logic [DW-1:0] d;
        m_ready = 0;
        for (int k = 0; k < DEPTH; k++) begin
            present({$urandom, $urandom}, 1, 8, rel, lat);
            if (!rel || lat != 1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_fill: got %0d late/missing releases want 0", bad);
        end
        d = {$urandom, $urandom};
        result_valid = 1; result_match = 1; result_data = d;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (result_reset !== 1'b0 || m_data !== q[0].data || m_beat !== q[0].beat) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: got %0d cycles with release or unstable head while full, want 0", bad);
        end
        m_ready = 1; tick(); m_ready = 0;
        checks++;
        if (result_reset !== 1'b0 || m_data !== q[0].data || q.size() != DEPTH - 1) begin
            errors++;
            $display("FAIL full_pop_defer: got rr=%0b md=%h want rr=0 md=%h", result_reset, m_data, q[0].data);
        end
        tick();
        checks++;
        if (result_reset !== 1'b1 || q.size() != DEPTH || q[DEPTH-1].data !== d) begin
            errors++;
            $display("FAIL full_pop_capture: got rr=%0b want 1", result_reset);
        end
        tick();
        result_valid = 0; result_match = 0;
        m_ready = 1; bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_valid !== 1'b1 || m_data !== q[0].data || m_beat !== q[0].beat) bad++;
            tick();
        end
        m_ready = 0;
        checks++;
        if (bad != 0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got %0d bad entries mv=%0b want 0 0", bad, m_valid);
        end
        checks++;
        if (match_count !== CW'(mdl_match)) begin
            errors++;
            $display("FAIL bp_match_count: got %0d want %0d", match_count, mdl_match);
        end
    endtask

    task automatic test_counters();
        bit rel; int lat;
        clear = 1; tick(); clear = 0;
        checks++;
        if (match_count !== '0 || done_count !== '0) begin
            errors++;
            $display("FAIL cnt_clear: got mc=%0d dc=%0d want 0 0", match_count, done_count);
        end
        m_ready = 1;
        for (int k = 0; k < CMAX + 1; k++) present({$urandom, $urandom}, 1, 8, rel, lat);
        checks++;
        if (match_count !== CW'(CMAX)) begin
            errors++;
            $display("FAIL match_saturate: got %0d want %0d", match_count, CMAX);
        end
        result_valid = 1; result_match = 0;
        for (int k = 0; k < CMAX + 2; k++) tick();
        result_valid = 0;
        checks++;
        if (done_count !== CW'(CMAX)) begin
            errors++;
            $display("FAIL done_saturate: got %0d want %0d", done_count, CMAX);
        end
        m_ready = 0; clear = 1;
        present(64'hC1EA_0000_0000_0001, 0, 8, rel, lat);
        clear = 0;
        checks++;
        if (match_count !== '0 || done_count !== '0 || !rel || m_data !== 64'hC1EA_0000_0000_0001) begin
            errors++;
            $display("FAIL clear_wins: got mc=%0d dc=%0d rel=%0b md=%h want 0 0 1 c1ea000000000001",
                     match_count, done_count, rel, m_data);
        end
        m_ready = 1; tick(); m_ready = 0;
    endtask

    task automatic test_reset_mid();
        bit rel; int lat;
        logic [DW-1:0] d;
        m_ready = 0;
        for (int k = 0; k < 3; k++) present({$urandom, $urandom}, 1, 8, rel, lat);
        result_valid = 1; result_match = 1; result_data = 64'h5555;
        tick();
        checks++;
        if (result_reset !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_ack: got rr=%0b want 1", result_reset);
        end
        areset_n = 0; tick();
        result_valid = 0; result_match = 0;
        checks++;
        if ({result_reset, m_valid, m_data, m_beat, match_count, done_count} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got rr=%0b mv=%0b md=%h mb=%0d mc=%0d dc=%0d want all zero",
                     result_reset, m_valid, m_data, m_beat, match_count, done_count);
        end
        areset_n = 1; tick();
        d = {$urandom, $urandom};
        present(d, 0, 8, rel, lat);
        checks++;
        if (!rel || m_data !== d || m_beat !== '0 || match_count !== 5'd1) begin
            errors++;
            $display("FAIL mid_reset_next: got rel=%0b md=%h mb=%0d mc=%0d want 1 %h 0 1",
                     rel, m_data, m_beat, match_count, d);
        end
        m_ready = 1; tick(); m_ready = 0;
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        logic [DW-1:0] exp_d;
        logic [BW-1:0] exp_b;
        for (int i = 0; i < 400; i++) begin
            data_valid   = 1'($urandom_range(0, 1));
            result_valid = ($urandom_range(0, 3) != 0);
            result_match = ($urandom_range(0, 3) != 0);
            result_data  = {$urandom, $urandom};
            m_ready      = ($urandom_range(0, 3) == 0);
            clear        = ($urandom_range(0, 63) == 0);
            tick();
            exp_d = (q.size() != 0) ? q[0].data : '0;
            exp_b = (q.size() != 0) ? q[0].beat : '0;
            if (result_reset !== mdl_ack || m_valid !== (q.size() != 0) || m_data !== exp_d ||
                m_beat !== exp_b || match_count !== CW'(mdl_match) || done_count !== CW'(mdl_done)) bad++;
        end
        data_valid = 0; result_valid = 0; result_match = 0; m_ready = 0; clear = 0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL random_traffic: got %0d divergent cycles want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_single_match();
        test_no_match();
        test_backpressure();
        test_counters();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matcher_result_collector.md
# matcher_result_collector

Consumer on the result side of the matcher. Captures each matched entry, tags it with the input-beat count at capture, and releases the matcher with a one-cycle `result_reset`. Buffers tagged results in a FIFO and drains them over a valid/ready master port. Also keeps match and no-match-completion statistics. When the FIFO is full it withholds `result_reset`, which stalls the matcher instead of dropping results.

## Interface
- `DATA_WIDTH`, 64: width of `result_data` and of the matched filter entry.
- `BEAT_WIDTH`, 32: width of the beat counter and of the tag.
- `FIFO_DEPTH`, 16: result FIFO entries; must be a power of two, at least 2.
- `CNT_WIDTH`, 32: width of the statistics counters.
- `fclk` in 1: clock.
- `areset_n` in 1: reset, synchronous, active-low; clock `fclk`.
- `data_valid` in 1: same strobe that qualifies the matcher's `input_stream`; one beat per high cycle.
- `result_valid` in 1: matcher result present (a match, or a filter pass completed).
- `result_match` in 1: matcher holds a match; `result_data` is valid.
- `result_data` in `DATA_WIDTH`: matched filter entry.
- `result_reset` out 1: one-cycle release pulse to the matcher.
- `m_valid` out 1: output entry available.
- `m_ready` in 1: downstream accepts.
- `m_data` out `DATA_WIDTH`: matched entry.
- `m_beat` out `BEAT_WIDTH`: beat tag of that entry.
- `match_count` out `CNT_WIDTH`: matches captured.
- `done_count` out `CNT_WIDTH`: no-match completions seen.
- `clear` in 1: synchronous clear of the statistics counters.

## Operation
- **Beat counter:** increments on every cycle with `data_valid`=1. Wraps modulo 2^`BEAT_WIDTH`.
- **FSM states:** IDLE, ACK.
- **IDLE:**
  - If `result_valid` && `result_match` && !full: write {`beat_cnt`, `result_data`} to the FIFO, increment `match_count`, go to ACK.
  - If `result_valid` && `result_match` && full: stay in IDLE and hold off. `result_reset` stays 0, so the matcher keeps the match.
- **ACK:** `result_reset`=1 for exactly this cycle, then return to IDLE unconditionally. A match still shown in the ACK cycle is ignored, which prevents a double capture.
- **No-match completion:** any cycle with `result_valid`=1 and `result_match`=0 increments `done_count`, in either state. No acknowledge is sent; the matcher self-clears.
- **Tag value:** `beat_cnt` as registered at the capture edge. A `data_valid` on the same edge is not included.
- **Counters:** saturate at all-ones; they do not wrap. `clear` zeros both. If a count event coincides with `clear`, `clear` wins. `clear` does not affect the FIFO, the FSM or `beat_cnt`.
- **FIFO:** first-word-fall-through. `m_valid` = !empty. Pop on `m_valid` && `m_ready`.
- **Full/empty rules:**
  - "full" is evaluated from the registered occupancy. A pop in the same cycle does not free a slot for a same-cycle write.
  - Push and pop in the same cycle while not full and not empty leave occupancy unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Reset:** reset mid-operation discards FIFO contents and any pending ACK. The FSM goes to IDLE; all counters and pointers go to 0.

## Timing
- **Reset values:** `result_reset`=0, `m_valid`=0, `m_data`=0, `m_beat`=0, `match_count`=0, `done_count`=0.
- **Capture to release:** capture at edge N; `result_reset` is high during cycle N+1 and registered.
- **Write to output:** FIFO write at edge N; `m_valid` is high from cycle N+1 if the FIFO was empty.
- **Back-to-back matches:** minimum spacing is 2 cycles (IDLE, ACK).
- **Sustained rate:** at most one capture per 2 cycles. One pop per cycle.
- **Outputs:** `m_data`/`m_beat` stay stable while `m_valid` && !`m_ready`.

## Structure
- **Package `matcher_pkg`:**
  - FSM state enum (IDLE, ACK).
  - FIFO entry typedef {beat, data}.
  - Default width constants (`DATA_WIDTH`=64, `BEAT_WIDTH`=32).
- **Sub-module `matcher_result_fifo`:** parameterised FWFT FIFO, synchronous reset, exposing `full`, `empty` and `count`.
- **Top level:** FSM, beat counter and statistics stay in `matcher_result_collector`.

## Test plan
- **Single match:** 3 `data_valid` beats, then `result_valid`=`result_match`=1, `result_data`=0xDEADBEEF, held until release.
  - `result_reset` is high exactly 1 cycle, one cycle after capture.
  - `m_valid` high with `m_data`=0xDEADBEEF, `m_beat`=3; `match_count`=1.
- **No-match completion:** `result_valid`=1, `result_match`=0 for 1 cycle.
  - `done_count`=1, no `result_reset` pulse, FIFO stays empty.
- **Backpressure:** `m_ready`=0; present 17 matches with `FIFO_DEPTH`=16.
  - 16 entries are captured; the 17th is held with `result_reset`=0.
  - After one pop, the 17th is captured and `result_reset` pulses.
- **Full plus pop:** FIFO full; a pop and a pending match occur in the same cycle.
  - Write is deferred one cycle; occupancy goes 16, 15, 16.
- **Counters:** force `match_count` to all-ones and capture once more.
  - `match_count` stays all-ones.
  - `clear` asserted together with a match event yields `match_count`=0.
- **Mid-operation reset:** `areset_n` low during ACK with 3 FIFO entries.
  - All outputs return to reset values and `result_reset` pulse is aborted.
  - The next match after reset is tagged `m_beat`=0.
